// File: rtl/game_pkg.sv
// Shared constants for the frogger game controller: state encodings, geometry
// defaults and the frog/car bounding-box overlap test.
package game_pkg;

    localparam int COORD_W     = 10;
    localparam int BLOCKSIZE   = 32;
    localparam int LANE_BASE_Y = 256;

    localparam logic [2:0] ST_ATTRACT  = 3'd0;
    localparam logic [2:0] ST_PLAY     = 3'd1;
    localparam logic [2:0] ST_DYING    = 3'd2;
    localparam logic [2:0] ST_SCORED   = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;

    // Strict inequalities: boxes that merely touch do not collide; 11 bits so sums never wrap.
    function automatic logic box_overlap(
        input logic [10:0] fx,
        input logic [10:0] fy,
        input logic [10:0] cx,
        input logic [10:0] len,
        input logic [10:0] ly,
        input logic [10:0] bs
    );
        return (len != 11'd0) && (fx < cx + len) && (fx + bs > cx) &&
               (fy < ly + bs) && (fy + bs > ly);
    endfunction

endpackage

// File: rtl/game_ctrl_lane_scanner.sv
// Time-multiplexed frog/car collision scanner: one car slot per cycle after a
// frame_tick, producing a one-cycle done pulse with the accumulated hit.
module lane_scanner #(
    parameter int NUM_LANES     = 6,
    parameter int CARS_PER_LANE = 3,
    parameter int BLOCKSIZE     = game_pkg::BLOCKSIZE,
    parameter int LANE_BASE_Y   = game_pkg::LANE_BASE_Y,
    parameter int GOAL_Y        = 32
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    enable,
    input  logic                                    frame_tick,
    input  logic [9:0]                              frog_x,
    input  logic [9:0]                              frog_y,
    input  logic [NUM_LANES*CARS_PER_LANE*10-1:0]   car_x,
    input  logic [NUM_LANES*10-1:0]                 lane_len,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    hit,
    output logic                                    goal
);
    import game_pkg::*;

    localparam int NUM_SLOTS = NUM_LANES * CARS_PER_LANE;
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CAR_W     = (CARS_PER_LANE > 1) ? $clog2(CARS_PER_LANE) : 1;
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [9:0]        fx_r;
    logic [9:0]        fy_r;
    logic [LANE_W-1:0] lane_r;
    logic [CAR_W-1:0]  car_r;
    logic              busy_r;
    logic              done_r;
    logic              hit_r;

    logic [SLOT_W-1:0] slot_s;
    logic [9:0]        cx_s;
    logic [9:0]        len_s;
    logic [10:0]       lane_y_s;
    logic              overlap_s;
    logic              last_car_s;
    logic              last_s;

    // Geometry of the slot currently under test.
    always_comb begin
        slot_s     = SLOT_W'(lane_r) * SLOT_W'(CARS_PER_LANE) + SLOT_W'(car_r);
        cx_s       = car_x[slot_s*COORD_W +: COORD_W];
        len_s      = lane_len[lane_r*COORD_W +: COORD_W];
        lane_y_s   = 11'(LANE_BASE_Y) + 11'(lane_r) * 11'(BLOCKSIZE);
        overlap_s  = box_overlap({1'b0, fx_r}, {1'b0, fy_r}, {1'b0, cx_s}, {1'b0, len_s},
                                 lane_y_s, 11'(BLOCKSIZE));
        last_car_s = (car_r == CAR_W'(CARS_PER_LANE - 1));
        last_s     = last_car_s && (lane_r == LANE_W'(NUM_LANES - 1));
    end

    // Snapshot, slot walk and hit accumulation; disabling aborts a scan in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fx_r   <= 10'd0;
            fy_r   <= 10'd0;
            lane_r <= '0;
            car_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hit_r  <= 1'b0;
        end else if (!enable) begin
            lane_r <= '0;
            car_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hit_r  <= 1'b0;
        end else if (busy_r) begin
            hit_r <= hit_r | overlap_s;
            if (last_s) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
                lane_r <= '0;
                car_r  <= '0;
            end else if (last_car_s) begin
                done_r <= 1'b0;
                car_r  <= '0;
                lane_r <= lane_r + LANE_W'(1);
            end else begin
                done_r <= 1'b0;
                car_r  <= car_r + CAR_W'(1);
            end
        end else begin
            done_r <= 1'b0;
            if (frame_tick) begin
                fx_r   <= frog_x;
                fy_r   <= frog_y;
                hit_r  <= 1'b0;
                busy_r <= 1'b1;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hit  = hit_r;
    assign goal = ({1'b0, fy_r} < 11'(GOAL_Y));

endmodule

// File: rtl/game_ctrl.sv
// Frogger game controller: drives the collision scanner and runs the
// attract/play/dying/scored/gameover FSM with lives, score and level.
module game_ctrl #(
    parameter int NUM_LANES     = 6,
    parameter int CARS_PER_LANE = 3,
    parameter int BLOCKSIZE     = game_pkg::BLOCKSIZE,
    parameter int LANE_BASE_Y   = game_pkg::LANE_BASE_Y,
    parameter int GOAL_Y        = 32,
    parameter int INIT_LIVES    = 3,
    parameter int DEATH_FRAMES  = 30,
    parameter int WIN_FRAMES    = 30,
    parameter int SCORE_STEP    = 100,
    parameter int SCORE_W       = 16
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    frame_tick,
    input  logic                                    start,
    input  logic [9:0]                              frog_x,
    input  logic [9:0]                              frog_y,
    input  logic [NUM_LANES*CARS_PER_LANE*10-1:0]   car_x,
    input  logic [NUM_LANES*10-1:0]                 lane_len,
    output logic [2:0]                              game_state,
    output logic [2:0]                              lives,
    output logic [SCORE_W-1:0]                      score,
    output logic [3:0]                              level,
    output logic                                    frog_reset,
    output logic                                    freeze,
    output logic                                    scan_busy
);
    import game_pkg::*;

    localparam int MAX_FRAMES = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
    localparam int FRAME_W    = $clog2(MAX_FRAMES + 1);

    logic [2:0]         state_r, state_s;
    logic [2:0]         lives_r, lives_s;
    logic [SCORE_W-1:0] score_r, score_s;
    logic [3:0]         level_r, level_s;
    logic [FRAME_W-1:0] cnt_r, cnt_s;
    logic               frog_reset_r, frog_reset_s;
    logic               freeze_r;
    logic               start_q_r;

    logic               start_edge_s;
    logic [SCORE_W:0]   score_sum_s;
    logic               scan_busy_s, scan_done_s, scan_hit_s, scan_goal_s;

    lane_scanner #(
        .NUM_LANES     (NUM_LANES),
        .CARS_PER_LANE (CARS_PER_LANE),
        .BLOCKSIZE     (BLOCKSIZE),
        .LANE_BASE_Y   (LANE_BASE_Y),
        .GOAL_Y        (GOAL_Y)
    ) u_scanner (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (state_r == ST_PLAY),
        .frame_tick (frame_tick),
        .frog_x     (frog_x),
        .frog_y     (frog_y),
        .car_x      (car_x),
        .lane_len   (lane_len),
        .busy       (scan_busy_s),
        .done       (scan_done_s),
        .hit        (scan_hit_s),
        .goal       (scan_goal_s)
    );

    assign start_edge_s = start & ~start_q_r;
    assign score_sum_s  = {1'b0, score_r} + (SCORE_W + 1)'(SCORE_STEP);

    // Next-state logic for the game FSM and its counters.
    always_comb begin
        state_s      = state_r;
        lives_s      = lives_r;
        score_s      = score_r;
        level_s      = level_r;
        cnt_s        = cnt_r;
        frog_reset_s = 1'b0;
        case (state_r)
            ST_ATTRACT, ST_GAMEOVER: begin
                if (start_edge_s) begin
                    state_s      = ST_PLAY;
                    lives_s      = 3'(INIT_LIVES);
                    score_s      = '0;
                    level_s      = 4'd0;
                    frog_reset_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PLAY: begin
                if (scan_done_s && scan_goal_s) begin
                    state_s = ST_SCORED;
                    cnt_s   = '0;
                    score_s = score_sum_s[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
                    level_s = (level_r == 4'd15) ? 4'd15 : level_r + 4'd1;
                end else if (scan_done_s && scan_hit_s) begin
                    state_s = ST_DYING;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (frame_tick && (cnt_r == FRAME_W'(DEATH_FRAMES - 1))) begin
                    cnt_s = '0;
                    if (lives_r <= 3'd1) begin
                        state_s = ST_GAMEOVER;
                        lives_s = 3'd0;
                    end else begin
                        state_s      = ST_PLAY;
                        lives_s      = lives_r - 3'd1;
                        frog_reset_s = 1'b1;
                    end
                end else if (frame_tick) begin
                    cnt_s = cnt_r + FRAME_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_SCORED: begin
                if (frame_tick && (cnt_r == FRAME_W'(WIN_FRAMES - 1))) begin
                    cnt_s        = '0;
                    state_s      = ST_PLAY;
                    frog_reset_s = 1'b1;
                end else if (frame_tick) begin
                    cnt_s = cnt_r + FRAME_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_ATTRACT;
            end
        endcase
    end

    // Game state registers; freeze is registered from the next state so it tracks game_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_ATTRACT;
            lives_r      <= 3'(INIT_LIVES);
            score_r      <= '0;
            level_r      <= 4'd0;
            cnt_r        <= '0;
            frog_reset_r <= 1'b0;
            freeze_r     <= 1'b1;
            start_q_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            lives_r      <= lives_s;
            score_r      <= score_s;
            level_r      <= level_s;
            cnt_r        <= cnt_s;
            frog_reset_r <= frog_reset_s;
            freeze_r     <= (state_s != ST_PLAY);
            start_q_r    <= start;
        end
    end

    assign game_state = state_r;
    assign lives      = lives_r;
    assign score      = score_r;
    assign level      = level_r;
    assign frog_reset = frog_reset_r;
    assign freeze     = freeze_r;
    assign scan_busy  = scan_busy_s;

endmodule
